wdt_sleep_ctrl: RTL and testbench

Watchdog-timer and power-down sequencer for the PIC16C5x core. Sits beside the control unit and consumes its Q4 execute strobes for CLRWDT, SLEEP and OPTION. Owns the WDT counter, the WDT-assigned prescaler, the TO/PD status bits and the core run-enable that stalls the Q-cycle sequencer during sleep and oscillator restart. Its reset is power-on only; the WDT reset it issues goes to the rest of the chip, never back into this block.

---
 rtl/wdt_sleep_ctrl_if.sv | 43 ++++
 rtl/wdt_sleep_ctrl.sv | 142 ++++++++++++++
 tb/tb_wdt_sleep_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wdt_sleep_ctrl_if.sv
// Control-unit side of the watchdog / sleep sequencer: Q4 command strobes in,
// run-enable and STATUS bits out.
interface wdt_sleep_ctrl_if;
  logic       wdt_en;
  logic       clrwdt_exec;
  logic       sleep_exec;
  logic       option_exec;
  logic [5:0] option_val;
  logic       wake_req;
  logic       core_run;
  logic       wdt_reset;
  logic       to_n;
  logic       pd_n;
  logic       sleeping;

  modport master (
    output wdt_en,
    output clrwdt_exec,
    output sleep_exec,
    output option_exec,
    output option_val,
    output wake_req,
    input  core_run,
    input  wdt_reset,
    input  to_n,
    input  pd_n,
    input  sleeping
  );

  modport slave (
    input  wdt_en,
    input  clrwdt_exec,
    input  sleep_exec,
    input  option_exec,
    input  option_val,
    input  wake_req,
    output core_run,
    output wdt_reset,
    output to_n,
    output pd_n,
    output sleeping
  );
endinterface

// File: rtl/wdt_sleep_ctrl.sv
// PIC16C5x watchdog timer, WDT prescaler, TO/PD status and SLEEP/WAKE sequencing.
// Reset is power-on only; wdt_reset_o-equivalent pulse leaves the block, never re-enters it.
module wdt_sleep_ctrl #(
  parameter int unsigned WDT_BASE    = 1024,
  parameter int unsigned WAKE_CYCLES = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  wdt_sleep_ctrl_if.slave ctrl
);

  localparam logic [15:0] BaseLast = 16'(WDT_BASE - 1);
  localparam logic [7:0]  WakeLast = 8'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun,
    StSleep,
    StWake
  } state_e;

  state_e      state_q;
  logic [6:0]  pre_q, pre_d, pre_last;
  logic [15:0] base_q, base_d;
  logic        psa_q;
  logic [2:0]  ps_q;
  logic [7:0]  wake_cnt_q;

  logic core_run_q, wdt_reset_q, to_n_q, pd_n_q, sleeping_q;
  logic in_run, cmd_clear, cmd_option, tick, wdt_hit;

  // Bits 5:4 of W at OPTION belong to TMR0 and are not used here.
  logic unused_option;
  assign unused_option = ^ctrl.option_val[5:4];

  always_comb begin
    in_run     = (state_q == StRun);
    cmd_clear  = in_run & (ctrl.clrwdt_exec | ctrl.sleep_exec);
    cmd_option = in_run & ctrl.option_exec;
    pre_last   = 7'((8'd1 << ps_q) - 8'd1);
    tick       = ~psa_q | (pre_q == pre_last);
    wdt_hit    = ctrl.wdt_en & tick & (base_q == BaseLast);

    pre_d  = pre_q;
    base_d = base_q;
    if (!ctrl.wdt_en || cmd_clear) begin
      pre_d  = '0;
      base_d = '0;
    end else begin
      if (tick) begin
        pre_d  = '0;
        base_d = wdt_hit ? '0 : base_q + 16'd1;
      end else begin
        pre_d = pre_q + 7'd1;
      end
      // Tick uses the old ratio; only partial prescaler progress is discarded.
      if (cmd_option) pre_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q  <= '0;
      base_q <= '0;
      psa_q  <= 1'b1;
      ps_q   <= 3'b111;
    end else begin
      pre_q  <= pre_d;
      base_q <= base_d;
      if (cmd_option) begin
        psa_q <= ctrl.option_val[3];
        ps_q  <= ctrl.option_val[2:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      wake_cnt_q  <= '0;
      core_run_q  <= 1'b1;
      wdt_reset_q <= 1'b0;
      to_n_q      <= 1'b1;
      pd_n_q      <= 1'b1;
      sleeping_q  <= 1'b0;
    end else begin
      wdt_reset_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          // Sleep beats clear, clear beats a coincident timeout.
          if (ctrl.sleep_exec) begin
            state_q    <= StSleep;
            core_run_q <= 1'b0;
            sleeping_q <= 1'b1;
            to_n_q     <= 1'b1;
            pd_n_q     <= 1'b0;
          end else if (ctrl.clrwdt_exec) begin
            to_n_q <= 1'b1;
            pd_n_q <= 1'b1;
          end else if (wdt_hit) begin
            wdt_reset_q <= 1'b1;
            to_n_q      <= 1'b0;
          end
        end
        StSleep: begin
          if (wdt_hit || ctrl.wake_req) begin
            if (wdt_hit) begin
              wdt_reset_q <= 1'b1;
              to_n_q      <= 1'b0;
            end
            state_q    <= StWake;
            sleeping_q <= 1'b0;
            wake_cnt_q <= '0;
          end
        end
        StWake: begin
          if (wdt_hit) begin
            wdt_reset_q <= 1'b1;
            to_n_q      <= 1'b0;
          end
          if (wake_cnt_q == WakeLast) begin
            state_q    <= StRun;
            core_run_q <= 1'b1;
          end else begin
            wake_cnt_q <= wake_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= StRun;
          core_run_q <= 1'b1;
          sleeping_q <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl.core_run  = core_run_q;
  assign ctrl.wdt_reset = wdt_reset_q;
  assign ctrl.to_n      = to_n_q;
  assign ctrl.pd_n      = pd_n_q;
  assign ctrl.sleeping  = sleeping_q;

endmodule

// File: tb/tb_wdt_sleep_ctrl.sv
// Scoreboard bench for wdt_sleep_ctrl: directed scenarios plus random command
// traffic, checked each cycle against an elapsed-time reference model.
module tb_wdt_sleep_ctrl;

  localparam int Base = 16;
  localparam int Wake = 4;

  typedef struct packed {
    logic core_run;
    logic wdt_reset;
    logic to_n;
    logic pd_n;
    logic sleeping;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wdt_sleep_ctrl_if bus ();

  wdt_sleep_ctrl #(
    .WDT_BASE   (Base),
    .WAKE_CYCLES(Wake)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ctrl (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model: mode 0=run 1=sleep 2=wake.
  int   m_mode, m_phase, m_ticks, m_psa, m_ps, m_wake_left;
  exp_t m_out;

  task automatic model(input logic r, input logic en, input logic clr, input logic slp,
                       input logic opt, input logic [5:0] ov, input logic wk);
    int ratio;
    bit timeout, in_run;
    if (r) begin
      m_mode = 0; m_phase = 0; m_ticks = 0; m_psa = 1; m_ps = 7; m_wake_left = 0;
      m_out = '{core_run: 1'b1, wdt_reset: 1'b0, to_n: 1'b1, pd_n: 1'b1, sleeping: 1'b0};
      return;
    end
    ratio   = (m_psa != 0) ? (1 << m_ps) : 1;
    in_run  = (m_mode == 0);
    timeout = 1'b0;
    m_out.wdt_reset = 1'b0;
    if (!en || (in_run && (clr || slp))) begin
      m_phase = 0;
      m_ticks = 0;
    end else begin
      m_phase++;
      if (m_phase == ratio) begin
        m_phase = 0;
        m_ticks++;
        if (m_ticks == Base) begin
          m_ticks = 0;
          timeout = 1'b1;
        end
      end
      if (in_run && opt) m_phase = 0;
    end
    if (in_run && opt) begin
      m_psa = int'(ov[3]);
      m_ps  = int'(ov[2:0]);
    end
    case (m_mode)
      0: begin
        if (slp) begin
          m_mode = 1;
          m_out.core_run = 1'b0; m_out.sleeping = 1'b1; m_out.to_n = 1'b1; m_out.pd_n = 1'b0;
        end else if (clr) begin
          m_out.to_n = 1'b1; m_out.pd_n = 1'b1;
        end else if (timeout) begin
          m_out.wdt_reset = 1'b1; m_out.to_n = 1'b0;
        end
      end
      1: begin
        if (timeout || wk) begin
          if (timeout) begin
            m_out.wdt_reset = 1'b1; m_out.to_n = 1'b0;
          end
          m_mode = 2; m_out.sleeping = 1'b0; m_wake_left = Wake;
        end
      end
      default: begin
        if (timeout) begin
          m_out.wdt_reset = 1'b1; m_out.to_n = 1'b0;
        end
        m_wake_left--;
        if (m_wake_left == 0) begin
          m_mode = 0; m_out.core_run = 1'b1;
        end
      end
    endcase
  endtask

  task automatic cyc(input logic r, input logic en, input logic clr, input logic slp,
                     input logic opt, input logic [5:0] ov, input logic wk);
    @(negedge clk);
    rst = r;
    bus.wdt_en = en;
    bus.clrwdt_exec = clr;
    bus.sleep_exec = slp;
    bus.option_exec = opt;
    bus.option_val = ov;
    bus.wake_req = wk;
    @(posedge clk);
    model(r, en, clr, slp, opt, ov, wk);
    exp_q.push_back(m_out);
  endtask

  task automatic idle(input logic en, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, en, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL cycle %0d %s: got %b want %b", cycle, name, got, want);
    end
  endtask

  // Monitor: one expected record per clocked cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("core_run", bus.core_run, e.core_run);
        chk("wdt_reset", bus.wdt_reset, e.wdt_reset);
        chk("to_n", bus.to_n, e.to_n);
        chk("pd_n", bus.pd_n, e.pd_n);
        chk("sleeping", bus.sleeping, e.sleeping);
      end
    end
  end

  initial begin
    logic en;
    bus.wdt_en = 1'b1; bus.clrwdt_exec = 1'b0; bus.sleep_exec = 1'b0;
    bus.option_exec = 1'b0; bus.option_val = 6'd0; bus.wake_req = 1'b0;

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // PSA=0: pulses every Base cycles.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, 1'b0);
    idle(1'b1, 40);

    // PSA=1 PS=2: cleared every 60 cycles, then left to expire at 64.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b001010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 59);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    end
    idle(1'b1, 70);

    // Sleep, wake by request after 10 cycles.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    idle(1'b1, 10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    idle(1'b1, 8);

    // PSA=0 sleep with no wake request: timeout wakes.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    idle(1'b1, 30);

    // Clear on the timeout edge; wake request on the sleep timeout edge.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    idle(1'b1, 15);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    idle(1'b1, 15);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    idle(1'b1, 15);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    idle(1'b1, 8);

    // WDT disabled: no timeouts, sleep ends only on request.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b0);
    idle(1'b0, 1000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    idle(1'b0, 50);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    idle(1'b0, 6);

    // Reset in WAKE.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    idle(1'b1, 2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    idle(1'b1, 3);

    // Random traffic; wdt_en only changes across a reset.
    for (int blk = 0; blk < 6; blk++) begin
      en = (blk == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(1'b1, en, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
      cyc(1'b0, en, 1'b1, 1'b0, 1'b1, 6'($urandom_range(0, 15)), 1'b0);
      for (int i = 0; i < 500; i++) begin
        cyc(1'($urandom_range(0, 399) == 0), en,
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 39) == 0), 6'($urandom),
            1'($urandom_range(0, 24) == 0));
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
